// File: rtl/nn_stream_wrapper.sv
// ============================================================================
// Module   : nn_stream_wrapper
// Function : Frame I/O wrapper for a layer pipeline. It fills an input buffer
//            from a valid/ready stream, runs the core with req/ack, and drains
//            an output buffer as a stream with a last marker.
// Option   : NN_STREAM_RELU_EN - when defined, negative output words become 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nn_stream_wrapper #(
    parameter int DW    = 8,
    parameter int N_IN  = 2,
    parameter int N_OUT = 1,
    localparam int IAW  = (N_IN  > 1) ? $clog2(N_IN)  : 1,
    localparam int OAW  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [DW-1:0]  in_data,
    output logic           in_ready,
    output logic           core_req,
    input  logic           core_ack,
    input  logic [IAW-1:0] core_raddr,
    output logic [DW-1:0]  core_rdata,
    input  logic           core_wen,
    input  logic [OAW-1:0] core_waddr,
    input  logic [DW-1:0]  core_wdata,
    output logic           out_valid,
    output logic [DW-1:0]  out_data,
    output logic           out_last,
    input  logic           out_ready,
    output logic           done
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [IAW-1:0] c_ILAST = IAW'(N_IN - 1);
    localparam logic [OAW-1:0] c_OLAST = OAW'(N_OUT - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IAW-1:0] r_icnt;
    logic [IAW-1:0] w_icnt_nxt;
    logic [OAW-1:0] r_ocnt;
    logic [OAW-1:0] w_ocnt_nxt;

    logic           r_in_ready;
    logic           r_core_req;
    logic           r_out_valid;
    logic           r_out_last;
    logic           r_done;
    logic           w_done_nxt;
    logic [DW-1:0]  r_core_rdata;

    logic [DW-1:0]  r_ibuf [0:N_IN-1];
    logic [DW-1:0]  r_obuf [0:N_OUT-1];

    logic           w_in_xfer;
    logic           w_out_xfer;
    logic           w_raddr_ok;
    logic           w_waddr_ok;
    logic [DW-1:0]  w_obuf_word;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;
    assign w_raddr_ok = ({1'b0, core_raddr} < (IAW + 1)'(N_IN));
    assign w_waddr_ok = ({1'b0, core_waddr} < (OAW + 1)'(N_OUT));

    always_comb begin
        w_state_nxt = r_state;
        w_icnt_nxt  = r_icnt;
        w_ocnt_nxt  = r_ocnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_in_xfer) begin
                    if (r_icnt == c_ILAST) begin
                        w_icnt_nxt  = '0;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_icnt_nxt  = r_icnt + IAW'(1);
                    end
                end
            end
            S_RUN: begin
                if (core_ack) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_out_xfer) begin
                    if (r_ocnt == c_OLAST) begin
                        w_ocnt_nxt  = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_ocnt_nxt  = r_ocnt + OAW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // Handshake outputs are registered copies of the next state, so they
    // stay low during reset even though the state itself resets to LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_LOAD;
            r_icnt      <= '0;
            r_ocnt      <= '0;
            r_in_ready  <= 1'b0;
            r_core_req  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_icnt      <= w_icnt_nxt;
            r_ocnt      <= w_ocnt_nxt;
            r_in_ready  <= (w_state_nxt == S_LOAD);
            r_core_req  <= (w_state_nxt == S_RUN);
            r_out_valid <= (w_state_nxt == S_DRAIN);
            r_out_last  <= (w_state_nxt == S_DRAIN) && (w_ocnt_nxt == c_OLAST);
            r_done      <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_xfer && (r_state == S_LOAD)) begin
            r_ibuf[r_icnt] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_core_rdata <= '0;
        end else begin
            r_core_rdata <= w_raddr_ok ? r_ibuf[core_raddr] : '0;
        end
    end

    // Unwritten entries deliberately keep the previous frame's results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_OUT; i++) begin
                r_obuf[i] <= '0;
            end
        end else if ((r_state == S_RUN) && core_wen && w_waddr_ok) begin
            r_obuf[core_waddr] <= core_wdata;
        end
    end

    assign w_obuf_word = r_obuf[r_ocnt];

`ifdef NN_STREAM_RELU_EN
    assign out_data = w_obuf_word[DW-1] ? '0 : w_obuf_word;
`else
    assign out_data = w_obuf_word;
`endif

    assign in_ready   = r_in_ready;
    assign core_req   = r_core_req;
    assign core_rdata = r_core_rdata;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_nn_stream_wrapper.sv
// ============================================================================
// Module   : tb_nn_stream_wrapper
// Function : Randomized scoreboard bench for nn_stream_wrapper (N_IN=3, N_OUT=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nn_stream_wrapper;

    localparam int DW      = 8;
    localparam int N_IN    = 3;
    localparam int N_OUT   = 3;
    localparam int IAW     = 2;
    localparam int OAW     = 2;
    localparam int NFRAMES = 40;
    localparam int LIMIT   = 20000;

    logic           clk        = 1'b0;
    logic           rst        = 1'b0;
    logic           in_valid   = 1'b0;
    logic [DW-1:0]  in_data    = '0;
    logic           in_ready;
    logic           core_req;
    logic           core_ack   = 1'b0;
    logic [IAW-1:0] core_raddr = '0;
    logic [DW-1:0]  core_rdata;
    logic           core_wen   = 1'b0;
    logic [OAW-1:0] core_waddr = '0;
    logic [DW-1:0]  core_wdata = '0;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic           out_last;
    logic           out_ready  = 1'b0;
    logic           done;

    nn_stream_wrapper #(.DW(DW), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .core_req(core_req), .core_ack(core_ack),
        .core_raddr(core_raddr), .core_rdata(core_rdata),
        .core_wen(core_wen), .core_waddr(core_waddr), .core_wdata(core_wdata),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int frames_done = 0;

    logic [DW-1:0] q_in[$];
    logic [DW:0]   q_out[$];
    logic [DW-1:0] model_obuf [0:N_OUT-1] = '{default: '0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef NN_STREAM_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic core_write(input logic wen, input int addr);
        core_wen   = wen;
        core_waddr = OAW'(addr);
        core_wdata = DW'($urandom);
        if (wen && addr < N_OUT) model_obuf[addr] = core_wdata;
    endtask

    // Core model: reads the whole frame back, writes a random subset of results.
    initial begin
        logic [DW-1:0] fw [0:3];
        forever begin
            @(negedge clk);
            if (!rst) begin
                core_wen = 1'b0;
                core_ack = 1'b0;
            end else if (!core_req) begin
                core_wen   = ($urandom_range(0, 5) == 0);
                core_ack   = ($urandom_range(0, 5) == 0);
                core_waddr = OAW'($urandom_range(0, 3));
                core_wdata = DW'($urandom);
                core_raddr = IAW'($urandom_range(0, 3));
            end else begin
                core_wen = 1'b0;
                core_ack = 1'b0;
                check("frame_queued", 32'(q_in.size() >= N_IN), 32'd1);
                for (int i = 0; i < 4; i++) fw[i] = (i < N_IN && q_in.size() > 0) ? q_in.pop_front() : '0;
                for (int a = 0; a <= 4; a++) begin
                    if (a > 0) check($sformatf("core_rdata[%0d]", a - 1), 32'(core_rdata), 32'(fw[a-1]));
                    if (a < 4) core_raddr = IAW'(a);
                    check("core_req_held", 32'(core_req), 32'd1);
                    @(negedge clk);
                end
                for (int w = $urandom_range(0, 4); w > 0; w--) begin
                    core_write($urandom_range(0, 1) == 1, $urandom_range(0, 3));
                    @(negedge clk);
                end
                core_write($urandom_range(0, 1) == 1, $urandom_range(0, 3));
                core_ack = 1'b1;
                for (int j = 0; j < N_OUT; j++) q_out.push_back({(j == N_OUT - 1), relu(model_obuf[j])});
                @(negedge clk);
                core_ack = 1'b0;
                core_wen = 1'b0;
                check("ack_req_drop", 32'(core_req), 32'd0);
                check("ack_out_valid", 32'(out_valid), 32'd1);
            end
        end
    end

    // Output monitor with random back-pressure and occasional 4-cycle stalls.
    initial begin
        int  stall = 0;
        logic last_seen = 1'b0;
        logic [DW:0] exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_seen = 1'b0;
            end else begin
                check("done", 32'(done), 32'(last_seen));
                if (last_seen) begin
                    check("in_ready_after_done", 32'(in_ready), 32'd1);
                    check("out_valid_after_done", 32'(out_valid), 32'd0);
                end
                last_seen = 1'b0;
                if (stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                end else if ($urandom_range(0, 9) == 0) begin
                    out_ready = 1'b0;
                    stall = 3;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                if (out_valid) begin
                    if (q_out.size() == 0) begin
                        check("spurious_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        exp = q_out[0];
                        check("out_data", 32'(out_data), 32'(exp[DW-1:0]));
                        check("out_last", 32'(out_last), 32'(exp[DW]));
                        if (out_ready) begin
                            void'(q_out.pop_front());
                            if (exp[DW]) begin
                                last_seen = 1'b1;
                                frames_done++;
                            end
                        end
                    end
                end
            end
        end
    end

    // Input driver, directed reset checks, and run control.
    initial begin
        int cyc = 0;
        int wcnt = 0;
        int frames_sent = 0;
        logic check_run = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_core_req", 32'(core_req), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_core_rdata", 32'(core_rdata), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        check("partial_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midframe_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        while ((frames_sent < NFRAMES || frames_done < NFRAMES) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (check_run) begin
                check("run_in_ready", 32'(in_ready), 32'd0);
                check("run_core_req", 32'(core_req), 32'd1);
                check_run = 1'b0;
            end
            if (frames_sent < NFRAMES || !in_ready) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = DW'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                q_in.push_back(in_data);
                wcnt++;
                if (wcnt == N_IN) begin
                    wcnt = 0;
                    frames_sent++;
                    check_run = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        if (cyc >= LIMIT) check("timeout_frames_done", 32'(frames_done), 32'(NFRAMES));
        repeat (2) @(negedge clk);
        check("final_in_ready", 32'(in_ready), 32'd1);
        check("scoreboard_empty", 32'(q_out.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
